if_id_register: RTL

- Pipeline register between instruction fetch and decode in the pipelined RISC-V core.
- Captures the fetched PC from the PC register, PC+4, and the instruction word from instruction memory.
- Pre-decodes the register fields that the hazard unit uses for load-use detection.
- Supports stall (hold) and flush (bubble insertion) and keeps saturating stall and flush event counters for debug.

---
 rtl/if_id_register_if.sv | 33 +++
 rtl/if_id_register.sv | 110 +++++++++++
 2 files changed

// File: rtl/if_id_register_if.sv
// Fetch-to-decode pipeline bundle: fetch-side controls and data in, decode-side
// registered view and debug counters out.
interface if_id_register_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic [N-1:0]     pc_in;
    logic [N-1:0]     instr_in;
    logic [N-1:0]     pc_out;
    logic [N-1:0]     pc_plus4_out;
    logic [N-1:0]     instr_out;
    logic             valid_out;
    logic [4:0]       rs1_out;
    logic [4:0]       rs2_out;
    logic [4:0]       rd_out;
    logic [6:0]       opcode_out;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output stall, flush, pc_in, instr_in,
        input  pc_out, pc_plus4_out, instr_out, valid_out,
        input  rs1_out, rs2_out, rd_out, opcode_out, stall_count, flush_count
    );

    modport slave (
        input  stall, flush, pc_in, instr_in,
        output pc_out, pc_plus4_out, instr_out, valid_out,
        output rs1_out, rs2_out, rd_out, opcode_out, stall_count, flush_count
    );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall/flush, pre-decoded hazard fields and
// saturating stall/flush debug counters. Priority: flush > stall > load.
module if_id_register #(
    parameter int          N        = 32,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    if_id_register_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [N-1:0]     PC_RST  = N'(RESET_PC);
    localparam logic [N-1:0]     NOP_N   = N'(NOP);
    localparam logic [N-1:0]     FOUR    = N'(4);

    logic [N-1:0]     pc_q, pc_d;
    logic [N-1:0]     pc4_q, pc4_d;
    logic [N-1:0]     instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next-state selection; bubble paths use constants so X on instr_in never leaks.
    always_comb begin
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        opcode_d    = opcode_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.flush) begin
            pc_d     = bus.pc_in;
            pc4_d    = bus.pc_in + FOUR;
            instr_d  = NOP_N;
            valid_d  = 1'b0;
            rs1_d    = 5'd0;
            rs2_d    = 5'd0;
            rd_d     = 5'd0;
            opcode_d = 7'h13;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else if (bus.stall) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            pc_d     = bus.pc_in;
            pc4_d    = bus.pc_in + FOUR;
            instr_d  = bus.instr_in;
            valid_d  = 1'b1;
            rs1_d    = bus.instr_in[19:15];
            rs2_d    = bus.instr_in[24:20];
            rd_d     = bus.instr_in[11:7];
            opcode_d = bus.instr_in[6:0];
        end
    end

    // State registers with asynchronous reset to the bubble at the text base.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= PC_RST;
            pc4_q       <= PC_RST + FOUR;
            instr_q     <= NOP_N;
            valid_q     <= 1'b0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            opcode_q    <= 7'h13;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            opcode_q    <= opcode_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_plus4_out = pc4_q;
    assign bus.instr_out    = instr_q;
    assign bus.valid_out    = valid_q;
    assign bus.rs1_out      = rs1_q;
    assign bus.rs2_out      = rs2_q;
    assign bus.rd_out       = rd_q;
    assign bus.opcode_out   = opcode_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
endmodule
